// File: rtl/dram_addr_mux.sv
// dram_addr_mux -- DRAM row/column address multiplexer and RAS/CAS sequencer.
//
// Sequences one access per request through ROW -> COL -> CAS -> PRE, with
// optional periodic refresh (REF -> PRE) when DRAM_MUX_REFRESH_EN is defined.
// Every output is registered except ma, which is a combinational mux of the
// latched address (or the refresh row) gated by noe.
//
// Ports:
//   clk   in   clock, rising edge
//   rst   in   asynchronous active-high reset
//   req   in   access request (level), sampled only when the FSM can launch
//   addr  in   [2*MUX_W-1:0] row = addr[MUX_W-1:0], column = addr[2*MUX_W-1:MUX_W]
//   noe   in   active-low output enable; 1 forces ma to zero
//   ma    out  [MUX_W-1:0] multiplexed DRAM address
//   sel   out  0 = row on ma, 1 = column on ma
//   nras  out  row strobe, active-low
//   ncas  out  column strobe, active-low
//   busy  out  high in every state except IDLE
//   ack   out  one-cycle pulse in the last CAS cycle
//   rfsh  out  high during a refresh cycle
//
// Build option: define DRAM_MUX_REFRESH_EN to include the refresh interval
// counter, refresh row counter and the REF state. Without it rfsh stays 0.
module dram_addr_mux #(
  parameter int MUX_W            = 8,
  parameter int T_RCD            = 1,
  parameter int T_CAS            = 2,
  parameter int T_RP             = 2,
  parameter int REFRESH_INTERVAL = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic [2*MUX_W-1:0]   addr,
  input  logic                 noe,
  output logic [MUX_W-1:0]     ma,
  output logic                 sel,
  output logic                 nras,
  output logic                 ncas,
  output logic                 busy,
  output logic                 ack,
  output logic                 rfsh
);

  localparam int REF_CYC = T_RCD + 1 + T_CAS;
  localparam int CNT_MAX = (REF_CYC > T_RP) ? REF_CYC : T_RP;
  localparam int CW      = $clog2(CNT_MAX + 1);

  // Down-counter reload values: a phase of N cycles loads N-1 and exits at 0.
  localparam logic [CW-1:0] RCD_LD = CW'(T_RCD - 1);
  localparam logic [CW-1:0] CAS_LD = CW'(T_CAS - 1);
  localparam logic [CW-1:0] RP_LD  = CW'(T_RP - 1);
  localparam logic [CW-1:0] REF_LD = CW'(REF_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_ROW, S_COL, S_CAS, S_PRE, S_REF} state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [2*MUX_W-1:0]   r_addr;
  logic                 r_sel, r_nras, r_ncas, r_busy, r_ack, r_rfsh;
  logic                 w_launch;
  logic                 w_ref_go;
  logic [MUX_W-1:0]     w_ma;

  // The FSM may start a new operation from IDLE or straight out of the last
  // PRE cycle, which gives back-to-back accesses with no idle gap.
  assign w_launch = (r_state == S_IDLE) || (r_state == S_PRE && r_cnt == '0);

`ifdef DRAM_MUX_REFRESH_EN
  localparam int IW = (REFRESH_INTERVAL > 2) ? $clog2(REFRESH_INTERVAL) : 1;

  logic [IW-1:0]    r_ivl;
  logic             r_pend;
  logic [MUX_W-1:0] r_row;
  logic             w_tick;

  assign w_tick   = (r_ivl == IW'(REFRESH_INTERVAL - 1));
  assign w_ref_go = w_launch && r_pend;

  // A tick on the same edge that services the old request re-arms pending,
  // so requests are neither dropped nor merged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ivl  <= '0;
      r_pend <= 1'b0;
      r_row  <= '0;
    end else begin
      r_ivl  <= w_tick ? '0 : r_ivl + IW'(1);
      r_pend <= w_tick || (r_pend && !w_ref_go);
      if (r_state == S_REF && r_cnt == '0) r_row <= r_row + MUX_W'(1);
    end
  end
`else
  assign w_ref_go = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_sel   <= 1'b0;
      r_nras  <= 1'b1;
      r_ncas  <= 1'b1;
      r_busy  <= 1'b0;
      r_ack   <= 1'b0;
      r_rfsh  <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        S_ROW: begin
          if (r_cnt == '0) begin
            r_state <= S_COL;
            r_sel   <= 1'b1;
          end else r_cnt <= r_cnt - CW'(1);
        end
        // Single column-address setup cycle before CAS falls.
        S_COL: begin
          r_state <= S_CAS;
          r_ncas  <= 1'b0;
          r_cnt   <= CAS_LD;
          r_ack   <= (T_CAS == 1);
        end
        S_CAS: begin
          if (r_cnt == '0) begin
            r_state <= S_PRE;
            r_nras  <= 1'b1;
            r_ncas  <= 1'b1;
            r_sel   <= 1'b0;
            r_cnt   <= RP_LD;
          end else begin
            r_cnt <= r_cnt - CW'(1);
            r_ack <= (r_cnt == CW'(1));
          end
        end
        S_REF: begin
          if (r_cnt == '0) begin
            r_state <= S_PRE;
            r_nras  <= 1'b1;
            r_rfsh  <= 1'b0;
            r_cnt   <= RP_LD;
          end else r_cnt <= r_cnt - CW'(1);
        end
        S_IDLE, S_PRE: begin
          if (!w_launch) begin
            r_cnt <= r_cnt - CW'(1);
          end else if (w_ref_go) begin
            r_state <= S_REF;
            r_cnt   <= REF_LD;
            r_nras  <= 1'b0;
            r_ncas  <= 1'b1;
            r_sel   <= 1'b0;
            r_busy  <= 1'b1;
            r_rfsh  <= 1'b1;
          end else if (req) begin
            r_state <= S_ROW;
            r_cnt   <= RCD_LD;
            r_addr  <= addr;
            r_nras  <= 1'b0;
            r_ncas  <= 1'b1;
            r_sel   <= 1'b0;
            r_busy  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_nras  <= 1'b1;
            r_ncas  <= 1'b1;
            r_sel   <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_nras  <= 1'b1;
          r_ncas  <= 1'b1;
          r_sel   <= 1'b0;
          r_busy  <= 1'b0;
          r_rfsh  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_ma = r_sel ? r_addr[2*MUX_W-1:MUX_W] : r_addr[MUX_W-1:0];
`ifdef DRAM_MUX_REFRESH_EN
    if (r_rfsh) w_ma = r_row;
`endif
    if (noe) w_ma = '0;
  end

  assign ma   = w_ma;
  assign sel  = r_sel;
  assign nras = r_nras;
  assign ncas = r_ncas;
  assign busy = r_busy;
  assign ack  = r_ack;
  assign rfsh = r_rfsh;

endmodule

// File: doc/dram_addr_mux.md
DRAM_ADDR_MUX -- requirements
Module: dram_addr_mux

Interface
REQ-001 SHALL have parameter MUX_W, default 8: multiplexed address width; the full address is 2*MUX_W bits.
REQ-002 SHALL have parameter T_RCD, default 1: row-phase cycles, ≥1.
REQ-003 SHALL have parameter T_CAS, default 2: CAS-low cycles, ≥1.
REQ-004 SHALL have parameter T_RP, default 2: precharge cycles, ≥1.
REQ-005 SHALL have parameter REFRESH_INTERVAL, default 64: clocks between refresh requests, ≥2.
REQ-006 SHALL have the following ports:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst  in  1  reset; asynchronous and active-high.
- req  in  1  access request (level).
- addr  in  2*MUX_W  access address: row = addr[MUX_W-1:0], column = addr[2*MUX_W-1:MUX_W].
- noe  in  1  output enable, active-low.
- ma  out  MUX_W  multiplexed DRAM address.
- sel  out  1  0 = row selected, 1 = column selected.
- nras  out  1  row strobe, active-low.
- ncas  out  1  column strobe, active-low.
- busy  out  1  high while any access or refresh is in progress.
- ack  out  1  one-cycle completion pulse.
- rfsh  out  1  high during a refresh cycle.

Function
REQ-007 SHALL implement the state machine IDLE, ROW, COL, CAS, PRE, REF, with all outputs registered except ma.
REQ-008 SHALL sample req only in IDLE; on req=1, latch addr and enter ROW on the next edge.
REQ-009 SHALL ignore req while busy=1; requests are not queued.
REQ-010 SHALL, in ROW, drive nras=0, ncas=1, sel=0 for T_RCD cycles, then enter COL.
REQ-011 SHALL, in COL, drive nras=0, sel=1, ncas=1 for 1 cycle (column address setup), then enter CAS.
REQ-012 SHALL, in CAS, drive nras=0, ncas=0, sel=1 for T_CAS cycles, with ack=1 during the last CAS cycle only, then enter PRE.
- Latency: ack appears in cycle T_RCD+1+T_CAS after the sampling edge; this is 4 at default parameters.
REQ-013 SHALL, in PRE, drive nras=1, ncas=1, sel=0 for T_RP cycles, then return to IDLE.
REQ-014 SHALL, if req is still 1 on return to IDLE, start a new access (back-to-back operation); the requester drops req on ack.
REQ-015 SHALL drive busy=1 in ROW, COL, CAS, PRE and REF, and busy=0 only in IDLE.
REQ-016 SHALL drive ma as the latched row when sel=0 and the latched column when sel=1, or the refresh row in REF.
REQ-017 SHALL force ma to all zeros, combinationally, whenever noe=1, without affecting the FSM or strobes.
REQ-018 SHALL use down-counters reloaded on each state entry for phase timing; no phase may be shortened or extended by req or addr changes.

Reset
REQ-019 SHALL, while rst=1, immediately force state=IDLE, nras=1, ncas=1, sel=0, ack=0, busy=0, rfsh=0, latched address=0 (so ma=0), and all counters=0.
REQ-020 SHALL, on rst assertion mid-access, abort the access with no ack, and raise the strobes without waiting for a clock.
REQ-021 SHALL begin normal operation on the first rising clk edge after rst falls.

Configuration
REQ-022 SHALL, when macro DRAM_MUX_REFRESH_EN is defined, include the refresh interval counter, refresh row counter, and the REF state.
- The interval counter sets refresh-pending every REFRESH_INTERVAL clocks.
- Pending is serviced in IDLE with priority over req.
- REF drives nras=0, ncas=1, rfsh=1, sel=0, ma=refresh row for T_RCD+1+T_CAS cycles, then enters PRE.
- The refresh row increments after each refresh and wraps from 2^MUX_W-1 to 0.
- A pending flag arising during an access waits for IDLE and is never lost or doubled.
REQ-023 SHALL, without DRAM_MUX_REFRESH_EN, omit the refresh logic, tie rfsh to 0, and never enter REF.

Verification
REQ-024 Single access, defaults: addr=0xA55A, req pulsed 1 cycle →
- ma=0x5A with nras low in cycle 1.
- sel=1, ma=0xA5 in cycle 2.
- ncas low in cycles 3-4, ack in cycle 4.
- busy low after cycle 6.
REQ-025 req held high across ack → second ROW begins in the cycle after PRE ends; no ack gaps other than ROW+COL+CAS+PRE.
REQ-026 noe=1 during CAS → ma=0x00 while nras/ncas timing is unchanged; noe=0 → ma=0xA5 restored in the same cycle.
REQ-027 rst asserted in second CAS cycle → nras=ncas=1 before the next edge, no ack, and busy=0; after release, a new access completes normally.
REQ-028 With DRAM_MUX_REFRESH_EN, REFRESH_INTERVAL=8, MUX_W=2, and req asserted on the same edge as pending:
- REF runs first (rfsh=1, ncas=1), then the access follows.
- The refresh row cycles 0,1,2,3,0.
REQ-029 Without DRAM_MUX_REFRESH_EN, 200 idle cycles → rfsh=0, nras=1 throughout.
